// File: rtl/ep2_frame_decoder.sv
// OpenHPSDR protocol-1 host-to-radio (EP2) frame decoder.
// Locks on 7F 7F 7F, then emits one C&C register write and SAMPLES_PER_FRAME sample sets per frame.
module ep2_frame_decoder #(
    parameter int unsigned SAMPLES_PER_FRAME = 63,
    parameter int unsigned TIMEOUT_CYCLES    = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [6:0]  cc_addr,
    output logic        cc_ptt,
    output logic [31:0] cc_data,
    output logic        cc_valid,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic [15:0] tx_i,
    output logic [15:0] tx_q,
    output logic        sample_valid,
    output logic        sync_locked,
    output logic [7:0]  sync_err_count,
    output logic [7:0]  timeout_count
);
    localparam int unsigned SLOT_W = 6;
    localparam int unsigned TMO_W  = 16;
    localparam logic [7:0]  SYNC_BYTE = 8'h7F;

    typedef enum logic [1:0] {HUNT, SYNC, CC, SAMPLES} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_cnt_q, sync_cnt_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       cc_sr_q, cc_sr_d;
    logic [55:0]       smp_sr_q, smp_sr_d;

    logic [6:0]  cc_addr_q, cc_addr_d;
    logic        cc_ptt_q, cc_ptt_d;
    logic [31:0] cc_data_q, cc_data_d;
    logic        cc_valid_q, cc_valid_d;
    logic [15:0] audio_l_q, audio_l_d;
    logic [15:0] audio_r_q, audio_r_d;
    logic [15:0] tx_i_q, tx_i_d;
    logic [15:0] tx_q_q, tx_q_d;
    logic        sample_valid_q, sample_valid_d;
    logic        sync_locked_q, sync_locked_d;
    logic [7:0]  sync_err_q, sync_err_d;
    logic [7:0]  tmo_count_q, tmo_count_d;

    // Next-state: byte parsing has priority over the stall timeout.
    always_comb begin
        state_d        = state_q;
        sync_cnt_d     = sync_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        slot_d         = slot_q;
        tmo_d          = tmo_q;
        cc_sr_d        = cc_sr_q;
        smp_sr_d       = smp_sr_q;
        cc_addr_d      = cc_addr_q;
        cc_ptt_d       = cc_ptt_q;
        cc_data_d      = cc_data_q;
        cc_valid_d     = 1'b0;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        tx_i_d         = tx_i_q;
        tx_q_d         = tx_q_q;
        sample_valid_d = 1'b0;
        sync_err_d     = sync_err_q;
        tmo_count_d    = tmo_count_q;

        if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                HUNT: begin
                    if (rx_data != SYNC_BYTE) begin
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q == 2'd2) begin
                        state_d    = CC;
                        sync_cnt_d = '0;
                        byte_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 2'd1;
                    end
                end
                SYNC: begin
                    if (rx_data != SYNC_BYTE) begin
                        state_d    = HUNT;
                        sync_cnt_d = '0;
                        if (sync_err_q != 8'hFF) sync_err_d = sync_err_q + 8'd1;
                    end else if (sync_cnt_q == 2'd2) begin
                        state_d    = CC;
                        sync_cnt_d = '0;
                        byte_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 2'd1;
                    end
                end
                CC: begin
                    cc_sr_d    = {cc_sr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd4) begin
                        cc_valid_d = 1'b1;
                        cc_addr_d  = cc_sr_q[31:25];
                        cc_ptt_d   = cc_sr_q[24];
                        cc_data_d  = {cc_sr_q[23:0], rx_data};
                        byte_cnt_d = '0;
                        slot_d     = '0;
                        state_d    = SAMPLES;
                    end
                end
                SAMPLES: begin
                    // byte_cnt wraps naturally from 7 to 0 at each slot boundary
                    smp_sr_d   = {smp_sr_q[47:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        sample_valid_d = 1'b1;
                        audio_l_d      = smp_sr_q[55:40];
                        audio_r_d      = smp_sr_q[39:24];
                        tx_i_d         = smp_sr_q[23:8];
                        tx_q_d         = {smp_sr_q[7:0], rx_data};
                        if (slot_q == SLOT_W'(SAMPLES_PER_FRAME - 1)) begin
                            slot_d     = '0;
                            sync_cnt_d = '0;
                            state_d    = SYNC;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d    = HUNT;
                tmo_d      = '0;
                sync_cnt_d = '0;
                byte_cnt_d = '0;
                slot_d     = '0;
                if (tmo_count_q != 8'hFF) tmo_count_d = tmo_count_q + 8'd1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        sync_locked_d = (state_d != HUNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= HUNT;
            sync_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            slot_q         <= '0;
            tmo_q          <= '0;
            cc_sr_q        <= '0;
            smp_sr_q       <= '0;
            cc_addr_q      <= '0;
            cc_ptt_q       <= 1'b0;
            cc_data_q      <= '0;
            cc_valid_q     <= 1'b0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            tx_i_q         <= '0;
            tx_q_q         <= '0;
            sample_valid_q <= 1'b0;
            sync_locked_q  <= 1'b0;
            sync_err_q     <= '0;
            tmo_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            sync_cnt_q     <= sync_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            slot_q         <= slot_d;
            tmo_q          <= tmo_d;
            cc_sr_q        <= cc_sr_d;
            smp_sr_q       <= smp_sr_d;
            cc_addr_q      <= cc_addr_d;
            cc_ptt_q       <= cc_ptt_d;
            cc_data_q      <= cc_data_d;
            cc_valid_q     <= cc_valid_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            tx_i_q         <= tx_i_d;
            tx_q_q         <= tx_q_d;
            sample_valid_q <= sample_valid_d;
            sync_locked_q  <= sync_locked_d;
            sync_err_q     <= sync_err_d;
            tmo_count_q    <= tmo_count_d;
        end
    end

    assign cc_addr        = cc_addr_q;
    assign cc_ptt         = cc_ptt_q;
    assign cc_data        = cc_data_q;
    assign cc_valid       = cc_valid_q;
    assign audio_l        = audio_l_q;
    assign audio_r        = audio_r_q;
    assign tx_i           = tx_i_q;
    assign tx_q           = tx_q_q;
    assign sample_valid   = sample_valid_q;
    assign sync_locked    = sync_locked_q;
    assign sync_err_count = sync_err_q;
    assign timeout_count  = tmo_count_q;

endmodule
